memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Sequencing controller that shares the single-port main RAM between the pipeline's instruction-fetch port and data port. It sits between the datapath's cache interface and the RAM, grants one requester at a time through a small state machine, and returns per-port wait/load signals. Data requests win by default; a starvation counter forces an instruction grant after `STARVE_MAX` consecutive data grants.

## Interface
- `STARVE_MAX`, default 4: consecutive data grants allowed while an instruction request is pending; range 1..15.
- `CLK  in  1`: rising-edge clock.
- `nRST  in  1`: reset, synchronous, active-low.
- `iREN  in  1`: instruction read request.
- `iaddr  in  32`: instruction word address.
- `iwait  out  1`: instruction port stall; low only in the completion cycle.
- `iload  out  32`: instruction read data, valid when `iREN & ~iwait`.
- `dREN  in  1`: data read request.
- `dWEN  in  1`: data write request; `dREN` and `dWEN` both high is treated as a write.
- `daddr  in  32`: data word address.
- `dstore  in  32`: data write value.
- `dwait  out  1`: data port stall; low only in the completion cycle.
- `dload  out  32`: data read data, valid when `dREN & ~dwait`.
- `ramREN  out  1`, `ramWEN  out  1`: RAM strobes.
- `ramaddr  out  32`, `ramstore  out  32`: RAM address and write data.
- `ramload  in  32`: RAM read data.
- `ramstate  in  2`: 0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR.
- `icount  out  32`, `dcount  out  32`: completed-access counters (see Configuration).

## Operation
- States: IDLE, IACC, DACC. The state register and the 4-bit starvation counter `starve` are updated only on the clock edge.
- In IDLE, RAM strobes are low and both waits are high.
- Transitions from IDLE:
  - Data request and (`~iREN` or `starve < STARVE_MAX`) -> DACC.
  - Else `iREN` -> IACC.
  - Else stay in IDLE.
- In IACC:
  - Drive `ramREN=1`, `ramWEN=0`, `ramaddr=iaddr`.
  - On `ramstate==ACCESS`: `iwait=0`, `iload=ramload`, next state IDLE, `starve<=0`.
- In DACC:
  - Drive `ramaddr=daddr`, `ramstore=dstore`, `ramWEN=dWEN`, `ramREN=dREN & ~dWEN`.
  - On ACCESS: `dwait=0`, `dload=ramload`, next state IDLE.
  - `starve` increments (saturating at 15) only if `iREN` was high in the completion cycle.
- FREE, BUSY, ERROR: remain in the access state, wait stays high. ERROR is retried indefinitely.
- Requester drops its request mid-access (IACC with `~iREN`, DACC with `~dREN & ~dWEN`):
  - Abort: RAM strobes low that cycle, next state IDLE.
  - No completion, no counter change.
- `iload` and `dload` are always wired to `ramload`; only the wait signals qualify them.
- A requester must hold address and data stable until it sees wait low.

## Timing
- Reset values: state IDLE, `starve=0`, `iwait=1`, `dwait=1`, `ramREN=0`, `ramWEN=0`, `icount=0`, `dcount=0`. `ramaddr` and `ramstore` are 0 while in IDLE.
- Minimum access is 2 cycles: request sampled in IDLE in cycle N; strobes driven in cycle N+1; completion in N+1 if `ramstate==ACCESS` there.
- Back-to-back accesses have one IDLE bubble between completions.
- Completion outputs are combinational from state and `ramstate`. There is no registered output latency.
- Reset asserted mid-access: next edge forces IDLE. The in-flight access is dropped with no completion.
- Simultaneous `iREN` and data request with `starve==STARVE_MAX`: instruction wins. `starve` clears at its completion.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - `icount` and `dcount` increment by 1 on each instruction or data completion respectively.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: `icount` and `dcount` are tied to 0 and no counter flops are synthesized.

## Test plan
- **Reset:** `nRST=0` for 2 cycles with `iREN=1` -> `ramREN=0`, `iwait=1`. After release, the first IACC appears one cycle later.
- **Single fetch:** `iREN=1`, `iaddr=0x40`, `ramstate` BUSY, BUSY, then ACCESS with `ramload=0x8C010004` -> `iwait` low for exactly one cycle in the ACCESS cycle, `iload=0x8C010004`, `ramaddr=0x40` throughout IACC.
- **Write priority:** `iREN=1` and `dWEN=1` (`daddr=0x100`, `dstore=0xDEADBEEF`) together, RAM returns ACCESS immediately -> DACC first with `ramWEN=1`, `ramstore=0xDEADBEEF`; IACC follows after one IDLE cycle.
- **Starvation (`STARVE_MAX=4`):** `iREN` held high, data requests continuous, RAM always ACCESS -> exactly 4 data completions, then an instruction completion, then `starve=0`.
- **Abort:** enter DACC, drop `dREN` while `ramstate=BUSY` -> strobes low that cycle, IDLE next, no `dwait` low pulse, `dcount` unchanged.
- **Stats (`MEM_ARB_STATS_EN`):** 3 instruction and 2 data completions -> `icount=3`, `dcount=2`. Without the macro, both read 0.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache-side request/response and RAM-side bus bundle for memory_arbiter.
interface memory_arbiter_if;
  logic        iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload, icount, dcount;
  logic [1:0]  ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, icount, dcount
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, icount, dcount
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between fetch and data ports, data-first with starvation guard.
// Defining MEM_ARB_STATS_EN adds saturating completion counters on icount/dcount.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic            CLK,
  input logic            nRST,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t     state, next;
  logic [3:0] starve;
  logic       dreq, idone, ddone;
  assign dreq = bus.dREN | bus.dWEN;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state <= next;
      if (idone) starve <= '0;
      else if (ddone && bus.iREN && starve != 4'hF) starve <= starve + 4'd1;
    end
  end
  always_comb begin
    next         = state;
    idone        = 1'b0;
    ddone        = 1'b0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      IDLE: next = (dreq && (!bus.iREN || starve < SMAX)) ? DACC : bus.iREN ? IACC : IDLE;
      IACC: begin
        if (!bus.iREN) next = IDLE;
        else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (bus.ramstate == ACCESS) begin
            bus.iwait = 1'b0;
            idone     = 1'b1;
            next      = IDLE;
          end
        end
      end
      DACC: begin
        if (!dreq) next = IDLE;
        else begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          if (bus.ramstate == ACCESS) begin
            bus.dwait = 1'b0;
            ddone     = 1'b1;
            next      = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icnt, dcnt;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (idone && icnt != '1) icnt <= icnt + 32'd1;
      if (ddone && dcnt != '1) dcnt <= dcnt + 32'd1;
    end
  end
  assign bus.icount = icnt;
  assign bus.dcount = dcnt;
`else
  assign bus.icount = '0;
  assign bus.dcount = '0;
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench; expected completions are queued at request time and popped on wait-low.
module tb_memory_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  memory_arbiter_if bus();
  memory_arbiter #(.STARVE_MAX(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    bit          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t sb[$];
  int checks = 0;
  int errors = 0;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic smp;
    @(negedge CLK);
  endtask
  always @(negedge CLK) begin
    if (nRST && (!bus.iwait || !bus.dwait)) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else begin
        ent_t e;
        e = sb.pop_front();
        chk("port", {31'd0, !bus.dwait}, {31'd0, e.d});
        chk("addr", bus.ramaddr, e.addr);
        if (e.wr) begin
          chk("wen", {31'd0, bus.ramWEN}, 32'd1);
          chk("store", bus.ramstore, e.data);
        end else chk("load", e.d ? bus.dload : bus.iload, e.data);
      end
    end
  end
  task automatic acc(input bit d, input logic [31:0] a, input logic [31:0] v);
    if (d) begin
      bus.dREN  = 1'b1;
      bus.daddr = a;
    end else begin
      bus.iREN  = 1'b1;
      bus.iaddr = a;
    end
    bus.ramload  = v;
    bus.ramstate = 2'd2;
    sb.push_back('{d, 1'b0, a, v});
    tick;
    tick;
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.ramstate = 2'd0;
  endtask
  initial begin
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramstate = 2'd0; bus.ramload = '0;
    tick;
    smp;
    chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    chk("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_icount", bus.icount, 32'd0);
    chk("rst_dcount", bus.dcount, 32'd0);
    tick;
    nRST = 1'b1;
    bus.ramstate = 2'd1;
    sb.push_back('{1'b0, 1'b0, 32'h40, 32'h8C010004});
    smp;
    chk("rel_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    tick;
    smp;
    chk("f_ramREN", {31'd0, bus.ramREN}, 32'd1);
    chk("f_ramaddr0", bus.ramaddr, 32'h40);
    chk("f_iwait0", {31'd0, bus.iwait}, 32'd1);
    tick;
    smp;
    chk("f_ramaddr1", bus.ramaddr, 32'h40);
    chk("f_iwait1", {31'd0, bus.iwait}, 32'd1);
    tick;
    bus.ramstate = 2'd2;
    bus.ramload  = 32'h8C010004;
    smp;
    chk("f_iwait_done", {31'd0, bus.iwait}, 32'd0);
    tick;
    bus.iREN = 1'b0;
    bus.ramstate = 2'd0;
    smp;
    chk("f_iwait_after", {31'd0, bus.iwait}, 32'd1);
    // write and fetch together: data goes first, fetch after one idle bubble
    tick;
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    bus.ramstate = 2'd2; bus.ramload = 32'h12345678;
    sb.push_back('{1'b1, 1'b1, 32'h100, 32'hDEADBEEF});
    sb.push_back('{1'b0, 1'b0, 32'h80, 32'h12345678});
    smp;
    tick;
    smp;
    chk("w_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
    chk("w_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("w_dwait", {31'd0, bus.dwait}, 32'd0);
    tick;
    bus.dWEN = 1'b0;
    smp;
    chk("w_bubble_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("w_bubble_ramaddr", bus.ramaddr, 32'd0);
    chk("w_bubble_ramstore", bus.ramstore, 32'd0);
    tick;
    smp;
    chk("w_iwait", {31'd0, bus.iwait}, 32'd0);
    chk("w_iramREN", {31'd0, bus.ramREN}, 32'd1);
    tick;
    bus.iREN = 1'b0;
    smp;
    chk("w_starve_clr", {28'd0, dut.starve}, 32'd0);
    tick;
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    bus.ramload = 32'h5555AAAA; bus.ramstate = 2'd2;
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h200, 32'h5555AAAA});
    sb.push_back('{1'b0, 1'b0, 32'h300, 32'h5555AAAA});
    sb.push_back('{1'b1, 1'b0, 32'h200, 32'h5555AAAA});
    for (int k = 0; k < 12; k++) begin
      smp;
      if (k == 8) chk("s_starve_max", {28'd0, dut.starve}, 32'd4);
      if (k == 10) chk("s_starve_clr", {28'd0, dut.starve}, 32'd0);
      tick;
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    smp;
    chk("s_sb_drained", sb.size(), 32'd0);
    tick;
    bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = 2'd1;
    smp;
    tick;
    smp;
    chk("a_ramREN", {31'd0, bus.ramREN}, 32'd1);
    chk("a_ramaddr", bus.ramaddr, 32'h400);
    tick;
    bus.dREN = 1'b0;
    smp;
    chk("a_drop_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("a_drop_dwait", {31'd0, bus.dwait}, 32'd1);
    tick;
    smp;
    chk("a_idle", 32'(dut.state), 32'd0);
    chk("a_dcount", bus.dcount, STATS ? 32'd6 : 32'd0);
    chk("a_icount", bus.icount, STATS ? 32'd3 : 32'd0);
    tick;
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = 2'd1;
    smp;
    tick;
    smp;
    chk("r_ramREN", {31'd0, bus.ramREN}, 32'd1);
    tick;
    nRST = 1'b0;
    smp;
    tick;
    smp;
    chk("r_ramREN_rst", {31'd0, bus.ramREN}, 32'd0);
    chk("r_icount_rst", bus.icount, 32'd0);
    tick;
    bus.iREN = 1'b0;
    nRST = 1'b1;
    bus.ramstate = 2'd0;
    smp;
    tick;
    acc(1'b0, 32'h600, 32'hA1);
    acc(1'b1, 32'h700, 32'hB2);
    acc(1'b0, 32'h604, 32'hA3);
    acc(1'b1, 32'h704, 32'hB4);
    acc(1'b0, 32'h608, 32'hA5);
    smp;
    chk("st_icount", bus.icount, STATS ? 32'd3 : 32'd0);
    chk("st_dcount", bus.dcount, STATS ? 32'd2 : 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
